rx_symbol_deframer: RTL

Stage directly downstream of the receiver matched filter.
- Consumes the filter's signed 11-bit output stream and decimates it to one decision per symbol.
- Slices each decision to a BPSK bit, hunts for a 16-bit sync word, then packs a fixed-length payload into bytes.
- Bytes leave on a valid/ready handshake toward the packet/UART logic.

---
 rtl/rx_symbol_deframer_if.sv | 10 +
 rtl/rx_symbol_deframer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rx_symbol_deframer_if.sv
// Byte stream from the deframer toward packet/UART logic; byte_out is held while
// byte_valid is high and byte_ready is low.
interface rx_symbol_deframer_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/rx_symbol_deframer.sv
// Decimates matched-filter samples to BPSK bits, hunts the sync word, packs payload bytes.
// Decision on edge N is visible after edge N; a byte completing while the output is stalled is dropped (sticky overflow).
module rx_symbol_deframer #(
  parameter int          SPS           = 4,
  parameter int          SAMPLE_PHASE  = 2,
  parameter logic [15:0] SYNC_WORD     = 16'hA5F0,
  parameter int          PAYLOAD_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [10:0]       sample_in,
  input  logic                     sample_valid,
  input  logic                     slip,
  rx_symbol_deframer_if.master     byte_if,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     in_frame,
  output logic                     overflow
);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  phase;
  logic [15:0] sreg;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  asm_q;

  logic        decision;
  logic        dec_bit;
  logic [15:0] sreg_shift;
  logic [7:0]  asm_shift;
  logic        match;
  logic        byte_done;
  logic        last_byte;

  assign decision   = sample_valid && (phase == 4'(SAMPLE_PHASE));
  assign dec_bit    = (sample_in >= 11'sd0);
  assign sreg_shift = {sreg[14:0], dec_bit};
  assign asm_shift  = {asm_q[6:0], dec_bit};

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (match)     state_nxt = PAYLOAD;
      PAYLOAD: if (last_byte) state_nxt = HUNT;
      default:                state_nxt = HUNT;
    endcase
  end

  always_comb begin
    match     = 1'b0;
    byte_done = 1'b0;
    last_byte = 1'b0;
    in_frame  = 1'b0;
    case (state)
      HUNT: match = decision && (sreg_shift == SYNC_WORD);
      PAYLOAD: begin
        in_frame  = 1'b1;
        byte_done = decision && (bit_cnt == 3'd7);
        last_byte = byte_done && (byte_cnt == 8'(PAYLOAD_BYTES - 1));
      end
      default: ;
    endcase
  end

  // A slip only freezes the counter; the decision on that sample still counts.
  always_ff @(posedge clk) begin
    if (reset)
      phase <= 4'd0;
    else if (sample_valid && !slip)
      phase <= (phase == 4'(SPS - 1)) ? 4'd0 : phase + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || last_byte)
      sreg <= 16'd0;
    else if (decision)
      sreg <= sreg_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
      asm_q    <= 8'd0;
    end else if (match) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
    end else if (state == PAYLOAD && decision) begin
      bit_cnt <= bit_cnt + 3'd1;
      asm_q   <= asm_shift;
      if (byte_done)
        byte_cnt <= byte_cnt + 8'd1;
    end
  end

  // Output holding register: a new byte only replaces one that is gone or leaving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_if.byte_out   <= 8'd0;
      byte_if.byte_valid <= 1'b0;
      overflow           <= 1'b0;
      frame_start        <= 1'b0;
      frame_done         <= 1'b0;
    end else begin
      frame_start <= match;
      frame_done  <= last_byte;
      if (byte_done) begin
        if (!byte_if.byte_valid || byte_if.byte_ready) begin
          byte_if.byte_out   <= asm_shift;
          byte_if.byte_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (byte_if.byte_valid && byte_if.byte_ready) begin
        byte_if.byte_valid <= 1'b0;
      end
    end
  end

endmodule
